// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer: FSM state codes, pattern
// mode codes and the prescaler step-period helper.
package led_pkg;

  typedef logic [1:0] seq_state_t;
  typedef logic [1:0] pattern_mode_t;

  localparam seq_state_t ST_IDLE   = 2'd0;
  localparam seq_state_t ST_MANUAL = 2'd1;
  localparam seq_state_t ST_AUTO   = 2'd2;
  localparam seq_state_t ST_SWITCH = 2'd3;

  localparam pattern_mode_t MODE_COUNT = 2'd0;
  localparam pattern_mode_t MODE_SCAN  = 2'd1;
  localparam pattern_mode_t MODE_LFSR  = 2'd2;
  localparam pattern_mode_t MODE_ALT   = 2'd3;

  localparam logic [5:0] BASE_STEP_PERIOD = 6'd4;

  // Step period in clock cycles: 4, 8, 16 or 32.
  function automatic logic [5:0] step_period(input logic [1:0] speed_sel);
    return BASE_STEP_PERIOD << speed_sel;
  endfunction

  function automatic pattern_mode_t next_mode(input pattern_mode_t mode);
    case (mode)
      MODE_COUNT: return MODE_SCAN;
      MODE_SCAN:  return MODE_LFSR;
      MODE_LFSR:  return MODE_ALT;
      default:    return MODE_COUNT;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Bundle from the sequencer to the pattern datapath; the sequencer drives it
// through the master modport, the datapath listens through slave.
interface led_pattern_sequencer_if;
  import led_pkg::*;

  pattern_mode_t pattern_mode;
  logic          step_strobe;
  logic          mode_change;
  seq_state_t    seq_state;

  modport master (
    output pattern_mode,
    output step_strobe,
    output mode_change,
    output seq_state
  );

  modport slave (
    input pattern_mode,
    input step_strobe,
    input mode_change,
    input seq_state
  );

endinterface

// File: rtl/led_btn_debounce.sv
// Push-button front end: 2-FF synchroniser, stability debounce and a one-cycle
// pulse on each debounced press (release is ignored).
module led_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_next,
  output logic next_req
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] count;

  // The stable level only follows sync2 after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      count    <= '0;
    end else begin
      sync1    <= btn_next;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 != stable) begin
        if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          count  <= '0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

  assign next_req = stable & ~stable_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Mode/step control for the LED pattern datapath: manual or dwell-timed mode
// selection plus a speed-selectable step strobe.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DWELL_STEPS     = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    btn_next,
  input  logic                    auto_en,
  input  logic [1:0]              speed_sel,
  led_pattern_sequencer_if.master dp
);

  localparam int DWELL_W = $clog2(DWELL_STEPS + 1);

  logic               next_req;
  seq_state_t         state;
  seq_state_t         next_state;
  pattern_mode_t      mode;
  logic               mode_change_q;
  logic               strobe_q;
  logic [4:0]         presc;
  logic [4:0]         presc_next;
  logic [5:0]         period;
  logic [DWELL_W-1:0] dwell;
  logic               dwell_done;
  logic               running_now;
  logic               running_next;

  led_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_next(btn_next),
    .next_req(next_req)
  );

  assign dwell_done = strobe_q && (dwell == DWELL_W'(DWELL_STEPS - 1));

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   next_state = auto_en ? ST_AUTO : ST_MANUAL;
        ST_MANUAL: begin
          if (next_req)     next_state = ST_SWITCH;
          else if (auto_en) next_state = ST_AUTO;
        end
        ST_AUTO: begin
          if (next_req || dwell_done) next_state = ST_SWITCH;
          else if (!auto_en)          next_state = ST_MANUAL;
        end
        default:   next_state = auto_en ? ST_AUTO : ST_MANUAL;
      endcase
    end
  end

  // The strobe register is loaded with the compare against the count it will
  // hold next, so it is high in the same cycle the count sits at P-1.
  always_comb begin
    running_now  = (state == ST_MANUAL) || (state == ST_AUTO);
    running_next = (next_state == ST_MANUAL) || (next_state == ST_AUTO);
    period       = step_period(speed_sel);
    presc_next   = (running_now && running_next && !strobe_q) ? presc + 5'd1 : 5'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mode          <= MODE_COUNT;
      mode_change_q <= 1'b0;
      strobe_q      <= 1'b0;
      presc         <= '0;
      dwell         <= '0;
    end else begin
      state         <= next_state;
      presc         <= presc_next;
      strobe_q      <= running_next && ({1'b0, presc_next} >= (period - 6'd1));
      mode_change_q <= (next_state == ST_SWITCH);
      if (next_state == ST_SWITCH) begin
        mode <= next_mode(mode);
      end
      if ((state != ST_AUTO) || (next_state != ST_AUTO)) begin
        dwell <= '0;
      end else if (strobe_q) begin
        dwell <= dwell + DWELL_W'(1);
      end
    end
  end

  assign dp.pattern_mode = mode;
  assign dp.step_strobe  = strobe_q;
  assign dp.mode_change  = mode_change_q;
  assign dp.seq_state    = state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with DEBOUNCE_CYCLES=4 and
// DWELL_STEPS=3; expected outputs are queued per cycle and compared after each edge.
module tb_led_pattern_sequencer;
  import led_pkg::*;

  localparam int TB_DEB   = 4;
  localparam int TB_DWELL = 3;
  localparam int TB_P     = 4;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       btn_next;
  logic       auto_en;
  logic [1:0] speed_sel;

  led_pattern_sequencer_if dp_if ();

  led_pattern_sequencer #(
    .DEBOUNCE_CYCLES(TB_DEB),
    .DWELL_STEPS    (TB_DWELL)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .btn_next (btn_next),
    .auto_en  (auto_en),
    .speed_sel(speed_sel),
    .dp       (dp_if.master)
  );

  typedef struct {
    logic [1:0] mode;
    logic       strobe;
    logic       strobe_care;
    logic       mchg;
    logic [1:0] state;
    string      tag;
  } exp_t;

  typedef struct {
    logic       en;
    logic       aut;
    logic       btn;
    logic [1:0] spd;
    logic [1:0] mode;
    logic       strobe;
    logic       mchg;
    logic [1:0] state;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       tbl[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] mode_e;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic exp_t mkExp(logic [1:0] mode, logic strobe, logic care,
                                 logic mchg, logic [1:0] state, string tag);
    exp_t e;
    e.mode = mode; e.strobe = strobe; e.strobe_care = care;
    e.mchg = mchg; e.state = state; e.tag = tag;
    return e;
  endfunction

  function automatic vec_t mkVec(logic en, logic aut, logic btn, logic [1:0] spd,
                                 logic [1:0] mode, logic strobe, logic mchg, logic [1:0] state);
    vec_t v;
    v.en = en; v.aut = aut; v.btn = btn; v.spd = spd;
    v.mode = mode; v.strobe = strobe; v.mchg = mchg; v.state = state;
    return v;
  endfunction

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: output produced but no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    if (dp_if.pattern_mode !== e.mode || dp_if.mode_change !== e.mchg ||
        dp_if.seq_state !== e.state || (e.strobe_care && dp_if.step_strobe !== e.strobe)) begin
      errors++;
      $display("[TB] FAIL %s: got mode=%0d strobe=%0b mode_change=%0b state=%0d, expected mode=%0d strobe=%0b(care=%0b) mode_change=%0b state=%0d",
               e.tag, dp_if.pattern_mode, dp_if.step_strobe, dp_if.mode_change, dp_if.seq_state,
               e.mode, e.strobe, e.strobe_care, e.mchg, e.state);
    end
  endtask

  // Drive one cycle of inputs, queue what the DUT must show after the edge, then compare.
  task automatic applyStimulus(input logic en, input logic aut, input logic btn,
                               input logic [1:0] spd, input exp_t e);
    enable    = en;
    auto_en   = aut;
    btn_next  = btn;
    speed_sel = spd;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic idleStep(input logic aut, input logic [1:0] spd, input string tag);
    applyStimulus(1'b0, aut, 1'b0, spd, mkExp(mode_e, 1'b0, 1'b1, 1'b0, ST_IDLE, tag));
  endtask

  task automatic resetPulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    sb_q.push_back(mkExp(MODE_COUNT, 1'b0, 1'b1, 1'b0, ST_IDLE, {tag, "_async"}));
    checkOutput();
    @(posedge clock);
    #1;
    sb_q.push_back(mkExp(MODE_COUNT, 1'b0, 1'b1, 1'b0, ST_IDLE, {tag, "_held"}));
    checkOutput();
    reset_n = 1'b1;
    mode_e  = MODE_COUNT;
  endtask

  task automatic manualSpeedRun(input logic [1:0] spd, input int n);
    int p;
    p = TB_P << spd;
    idleStep(1'b0, spd, $sformatf("speed%0d_idle", spd));
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, spd,
                    mkExp(mode_e, (k % p) == (p - 1), 1'b1, 1'b0, ST_MANUAL,
                          $sformatf("speed%0d_k%0d", spd, k)));
    end
  endtask

  // Press held long enough to debounce: mode advances on the (TB_DEB+3)th edge.
  task automatic pressButton(input logic [1:0] new_mode);
    logic [1:0] old_mode;
    exp_t       e;
    old_mode = mode_e;
    for (int k = 1; k <= 8; k++) begin
      if (k < TB_DEB + 3)
        e = mkExp(old_mode, 1'b0, 1'b0, 1'b0, ST_MANUAL, $sformatf("press%0d_k%0d", new_mode, k));
      else if (k == TB_DEB + 3)
        e = mkExp(new_mode, 1'b0, 1'b1, 1'b1, ST_SWITCH, $sformatf("press%0d_switch", new_mode));
      else
        e = mkExp(new_mode, 1'b0, 1'b0, 1'b0, ST_MANUAL, $sformatf("press%0d_k%0d", new_mode, k));
      applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, e);
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0,
                    mkExp(new_mode, 1'b0, 1'b0, 1'b0, ST_MANUAL, $sformatf("release%0d_k%0d", new_mode, k)));
    end
    mode_e = new_mode;
  endtask

  // Auto-cycle expectations: ph counts cycles since entering AUTO; a dwell
  // switch lands at ph == DWELL*P and a press switch TB_DEB+2 edges after it starts.
  task automatic autoSequence(input int n, input int pa, input int pb);
    int   ph;
    logic btn;
    logic sw;
    exp_t e;
    ph = 0;
    for (int k = 0; k < n; k++) begin
      btn = ((k >= pa) && (k < pa + 10)) || ((k >= pb) && (k < pb + 10));
      sw  = (ph == TB_DWELL * TB_P) || (k == pa + TB_DEB + 2) || (k == pb + TB_DEB + 2);
      if (sw) begin
        mode_e = mode_e + 2'd1;
        e  = mkExp(mode_e, 1'b0, 1'b1, 1'b1, ST_SWITCH, $sformatf("auto_k%0d_switch", k));
        ph = 0;
      end else begin
        e  = mkExp(mode_e, (ph % TB_P) == (TB_P - 1), 1'b1, 1'b0, ST_AUTO, $sformatf("auto_k%0d", k));
        ph = ph + 1;
      end
      applyStimulus(1'b1, 1'b1, btn, 2'd0, e);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    btn_next  = 1'b0;
    auto_en   = 1'b0;
    speed_sel = 2'd0;
    mode_e    = MODE_COUNT;

    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      sb_q.push_back(mkExp(MODE_COUNT, 1'b0, 1'b1, 1'b0, ST_IDLE, $sformatf("reset_state%0d", i)));
      checkOutput();
    end
    reset_n = 1'b1;

    // Manual strobes at P=4, a held press (advance on its 7th edge), release, then a 2-cycle glitch.
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 1, 3));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].aut, tbl[i].btn, tbl[i].spd,
                    mkExp(tbl[i].mode, tbl[i].strobe, 1'b1, tbl[i].mchg, tbl[i].state,
                          $sformatf("table[%0d]", i)));
    end
    mode_e = 2'd1;

    manualSpeedRun(2'd1, 17);
    manualSpeedRun(2'd3, 33);

    resetPulse("reset_manual");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, mkExp(MODE_COUNT, 1'b0, 1'b1, 1'b0, ST_MANUAL, "manual_entry"));
    pressButton(2'd1);
    pressButton(2'd2);
    pressButton(2'd3);
    pressButton(2'd0);
    idleStep(1'b1, 2'd0, "idle_after_presses");

    // Press at k=58 debounces exactly when the third strobe expires the dwell (single advance);
    // press at k=80 cuts a dwell short.
    autoSequence(95, 58, 80);
    idleStep(1'b1, 2'd0, "auto_disable0");
    idleStep(1'b1, 2'd0, "auto_disable1");

    autoSequence(45, -100, -100);
    resetPulse("reset_auto");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
